// File: rtl/logic_unit_pkg.sv
// ============================================================================
// Module      : logic_unit_pkg
// Description : Shared types and constants for the logic_unit datapath leaf.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package logic_unit_pkg;

    typedef enum logic [1:0] {
        OP_AND  = 2'd0,
        OP_OR   = 2'd1,
        OP_XOR  = 2'd2,
        OP_PASS = 2'd3
    } op_e;

    localparam int OP_INV_BIT = 2;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        ACC  = 1'b1
    } acc_state_e;

endpackage

`default_nettype wire

// File: rtl/logic_unit_core.sv
// ============================================================================
// Module      : logic_unit_core
// Description : Combinational gate function. Normal path computes f(a, b);
//               fold path computes f(x, a). PASS always yields a.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module logic_unit_core
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_x,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_fold,
    input  logic [1:0]       i_op,
    output logic [WIDTH-1:0] o_f
);

    logic [WIDTH-1:0] w_lhs;
    logic [WIDTH-1:0] w_rhs;

    assign w_lhs = i_fold ? i_x : i_a;
    assign w_rhs = i_fold ? i_a : i_b;

    always_comb begin
        o_f = i_a;
        case (op_e'(i_op))
            OP_AND:  o_f = w_lhs & w_rhs;
            OP_OR:   o_f = w_lhs | w_rhs;
            OP_XOR:  o_f = w_lhs ^ w_rhs;
            OP_PASS: o_f = i_a;
            default: o_f = i_a;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/logic_unit.sv
// ============================================================================
// Module      : logic_unit
// Description : Registered bitwise logic unit with reduction flags and a
//               valid/ready output register. Define LOGIC_UNIT_ACCUM_EN to
//               enable multi-beat packet accumulation.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module logic_unit
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             in_first,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             red_and,
    output logic             red_or,
    output logic             red_xor
);

    logic             r_out_valid;
    logic [WIDTH-1:0] r_y;
    logic             r_red_and;
    logic             r_red_or;
    logic             r_red_xor;

    logic             w_accept;
    logic             w_load;
    logic [WIDTH-1:0] w_norm_f;
    logic [WIDTH-1:0] w_norm_y;
    logic [WIDTH-1:0] w_y_next;

    assign in_ready = !r_out_valid || out_ready;
    assign w_accept = in_valid && in_ready;

    logic_unit_core #(.WIDTH(WIDTH)) u_norm (
        .i_x    ('0),
        .i_a    (a),
        .i_b    (b),
        .i_fold (1'b0),
        .i_op   (op[1:0]),
        .o_f    (w_norm_f)
    );

    assign w_norm_y = op[OP_INV_BIT] ? ~w_norm_f : w_norm_f;

`ifdef LOGIC_UNIT_ACCUM_EN
    acc_state_e       r_state;
    acc_state_e       w_state_next;
    logic [WIDTH-1:0] r_acc;
    logic [2:0]       r_op;
    logic [WIDTH-1:0] w_fold;
    logic [WIDTH-1:0] w_acc_next;
    logic             w_start;

    logic_unit_core #(.WIDTH(WIDTH)) u_fold (
        .i_x    (r_acc),
        .i_a    (a),
        .i_b    (b),
        .i_fold (1'b1),
        .i_op   (r_op[1:0]),
        .o_f    (w_fold)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (w_accept) begin
            w_state_next = in_last ? IDLE : ACC;
        end
    end

    // A beat in IDLE or flagged in_first restarts the packet; a one-beat packet
    // behaves exactly like a normal-mode beat.
    always_comb begin
        w_start    = (r_state == IDLE) || in_first;
        w_load     = w_accept && in_last;
        w_acc_next = w_start ? a : w_fold;
        if (w_start) begin
            w_y_next = w_norm_y;
        end else begin
            w_y_next = r_op[OP_INV_BIT] ? ~w_fold : w_fold;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
            r_op  <= 3'b000;
        end else if (w_accept) begin
            r_acc <= w_acc_next;
            if (w_start) begin
                r_op <= op;
            end
        end
    end
`else
    logic w_unused;

    assign w_unused = in_first ^ in_last;
    assign w_load   = w_accept;
    assign w_y_next = w_norm_y;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_y         <= '0;
            r_red_and   <= 1'b0;
            r_red_or    <= 1'b0;
            r_red_xor   <= 1'b0;
        end else if (w_load) begin
            r_out_valid <= 1'b1;
            r_y         <= w_y_next;
            r_red_and   <= &w_y_next;
            r_red_or    <= |w_y_next;
            r_red_xor   <= ^w_y_next;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign y         = r_y;
    assign red_and   = r_red_and;
    assign red_or    = r_red_or;
    assign red_xor   = r_red_xor;

endmodule

`default_nettype wire

// File: tb/tb_logic_unit.sv
// ============================================================================
// Module      : tb_logic_unit
// Description : Self-checking bench for logic_unit (WIDTH=8); directed
//               literal cases plus randomized traffic against a packet model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_logic_unit;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [2:0]   op = 3'b000;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         in_first = 1'b0;
    logic         in_last = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] y;
    logic         red_and;
    logic         red_or;
    logic         red_xor;

    int passed = 0;
    int total  = 0;
    bit chk_en = 1'b0;

    logic         m_valid;
    logic [W-1:0] m_y;
`ifdef LOGIC_UNIT_ACCUM_EN
    logic [W-1:0] m_pkt[$];
    logic [2:0]   m_pkt_op;
    bit           m_in_pkt;
`endif

    logic_unit #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .in_first  (in_first),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .red_and   (red_and),
        .red_or    (red_or),
        .red_xor   (red_xor)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end else begin
            passed++;
        end
    endtask

    function automatic logic [W-1:0] combine(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] w);
        case (o)
            2'd0:    return x & w;
            2'd1:    return x | w;
            2'd2:    return x ^ w;
            default: return w;
        endcase
    endfunction

    function automatic logic [W-1:0] normal(input logic [2:0] o, input logic [W-1:0] aa, input logic [W-1:0] bb);
        logic [W-1:0] r;
        r = (o[1:0] == 2'd3) ? aa : combine(o[1:0], aa, bb);
        return o[2] ? ~r : r;
    endfunction

    // Reference: output register contents as seen by a consumer.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid = 1'b0;
            m_y     = '0;
`ifdef LOGIC_UNIT_ACCUM_EN
            m_pkt.delete();
            m_in_pkt = 1'b0;
            m_pkt_op = 3'b000;
`endif
        end else begin
            bit           acc;
            bit           ld;
            logic [W-1:0] ny;
            acc = in_valid && (!m_valid || out_ready);
            ld  = 1'b0;
            ny  = '0;
            if (acc) begin
`ifdef LOGIC_UNIT_ACCUM_EN
                if (in_first || !m_in_pkt) begin
                    if (in_last) begin
                        ny = normal(op, a, b);
                        ld = 1'b1;
                        m_in_pkt = 1'b0;
                    end else begin
                        m_pkt.delete();
                        m_pkt.push_back(a);
                        m_pkt_op = op;
                        m_in_pkt = 1'b1;
                    end
                end else begin
                    m_pkt.push_back(a);
                    if (in_last) begin
                        logic [W-1:0] r;
                        r = m_pkt[0];
                        for (int i = 1; i < m_pkt.size(); i++) r = combine(m_pkt_op[1:0], r, m_pkt[i]);
                        ny = m_pkt_op[2] ? ~r : r;
                        ld = 1'b1;
                        m_in_pkt = 1'b0;
                    end
                end
`else
                ny = normal(op, a, b);
                ld = 1'b1;
`endif
            end
            if (ld) begin
                m_valid = 1'b1;
                m_y     = ny;
            end else if (out_ready) begin
                m_valid = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("out_valid", out_valid, m_valid);
            check("in_ready", in_ready, !m_valid || out_ready);
            check("y", y, m_y);
            check("red_and", red_and, &m_y);
            check("red_or", red_or, |m_y);
            check("red_xor", red_xor, ^m_y);
        end
    end

    // Offers one beat and returns one cycle after it is accepted.
    task automatic send(input logic [2:0] o, input logic [W-1:0] aa, input logic [W-1:0] bb,
                        input logic f, input logic l);
        int n;
        n = 0;
        in_valid = 1'b1; op = o; a = aa; b = bb; in_first = f; in_last = l;
        while (!in_ready) begin
            if (n == 50) begin
                total++;
                $display("FAIL send_timeout: in_ready stuck low, required high within 50 cycles");
                break;
            end
            @(negedge clk); #1;
            n++;
        end
        @(negedge clk); #1;
        in_valid = 1'b0;
    endtask

    logic [W-1:0] sweep_exp [8] = '{8'h08, 8'h0E, 8'h06, 8'h0C, 8'hF7, 8'hF1, 8'hF9, 8'hF3};

    initial begin
        @(posedge clk); #1;
        chk_en = 1'b1;
        @(negedge clk); #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_y", y, 8'h00);
        check("rst_in_ready", in_ready, 1'b1);
        rst_n = 1'b1;
        @(negedge clk); #1;

        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            send(i[2:0], 8'h0C, 8'h0A, 1'b1, 1'b1);
            check("sweep_y", y, sweep_exp[i]);
            if (i == 0) check("sweep_red_xor", red_xor, 1'b1);
        end

        send(3'b010, 8'h3C, 8'h0F, 1'b1, 1'b1);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            check("bp_in_ready", in_ready, 1'b0);
            check("bp_y_hold", y, 8'h33);
        end
        out_ready = 1'b1;
        send(3'b000, 8'hF0, 8'h3C, 1'b1, 1'b1);
        check("bp_reload_y", y, 8'h30);
        check("bp_reload_valid", out_valid, 1'b1);

        send(3'b000, 8'hFF, 8'hFF, 1'b1, 1'b1);
        check("red_and_ff", red_and, 1'b1);
        send(3'b000, 8'hFE, 8'hFF, 1'b1, 1'b1);
        check("red_and_fe", red_and, 1'b0);
        check("red_or_fe", red_or, 1'b1);

`ifdef LOGIC_UNIT_ACCUM_EN
        @(negedge clk); #1;
        send(3'b000, 8'hF0, 8'h00, 1'b1, 1'b0);
        send(3'b000, 8'h3C, 8'h00, 1'b0, 1'b0);
        check("acc_nonlast_valid", out_valid, 1'b0);
        send(3'b000, 8'hFF, 8'h00, 1'b0, 1'b1);
        check("acc_and_y", y, 8'h30);
        check("acc_and_valid", out_valid, 1'b1);

        send(3'b110, 8'h0F, 8'h00, 1'b1, 1'b0);
        send(3'b110, 8'hF0, 8'h00, 1'b0, 1'b0);
        send(3'b110, 8'hAA, 8'h00, 1'b1, 1'b1);
        check("acc_restart_y", y, 8'h55);
`endif

        send(3'b000, 8'hF0, 8'h00, 1'b1, 1'b0);
        rst_n = 1'b0;
        #1;
        check("midrst_valid", out_valid, 1'b0);
        check("midrst_y", y, 8'h00);
        @(negedge clk); #1;
        rst_n = 1'b1;
        send(3'b001, 8'h01, 8'h02, 1'b1, 1'b1);
        check("post_rst_y", y, 8'h03);

        for (int i = 0; i < 600; i++) begin
            @(negedge clk); #1;
            in_valid  = ($urandom_range(0, 3) != 0);
            op        = 3'($urandom_range(0, 7));
            a         = W'($urandom);
            b         = W'($urandom);
            in_first  = ($urandom_range(0, 4) == 0);
            in_last   = ($urandom_range(0, 2) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
        end
        @(negedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/logic_unit.md
# logic_unit

Registered, parametrised bitwise logic unit: applies one of eight gate functions (AND/OR/XOR/PASS, each optionally inverted) across WIDTH-bit operands. It also produces reduction flags of the result, behind a valid/ready handshake with one output register. An optional accumulate mode folds a multi-beat packet of words into one result. Sits as a generic datapath leaf wherever gate-level vector ops or word-stream reductions are needed.

## Interface
- WIDTH, 8, operand/result width in bits (>= 1)
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  input beat offered
- in_ready  out  1  input beat accepted when in_valid && in_ready
- op  in  3  op[2] = invert result; op[1:0]: 0 AND, 1 OR, 2 XOR, 3 PASS(a)
- a, b  in  WIDTH  operands
- in_first  in  1  first beat of packet (accumulate mode only)
- in_last  in  1  last beat of packet (accumulate mode only)
- out_valid  out  1  result held
- out_ready  in  1  result consumed when out_valid && out_ready
- y  out  WIDTH  result
- red_and, red_or, red_xor  out  1 each  &y, |y, ^y of the registered y

## Operation
- Base function f(a,b) per op[1:0]; y = op[2] ? ~f : f. So 100=NAND, 101=NOR, 110=XNOR, 111=INV(~a).
- Normal mode: each accepted beat loads y = result and sets out_valid. Reduction flags are registered with y and computed from the final y.
- in_ready = !out_valid || out_ready; simultaneous drain and load in one cycle is legal.
- out_valid clears on drain with no new load; y and flags hold their last value while out_valid=0.
- Output stable (y, flags unchanged) while out_valid && !out_ready.
- Reset: out_valid=0, y=0, red_*=0, accumulator=0, state IDLE; in_ready=1 after reset. Reset mid-packet discards the partial accumulation.

## Timing
- Latency: result visible on y/out_valid the cycle after acceptance (1 cycle).
- Throughput: one beat per cycle with out_ready held high.
- Accumulate mode: out_valid rises the cycle after the in_last beat is accepted. Non-last beats never raise out_valid.
- Accumulate state machine, IDLE -> ACC on an accepted beat with !in_last.
  - ACC -> IDLE on an accepted in_last beat.
  - in_first in ACC: partial discarded, restart from this beat, stay ACC (or IDLE if also in_last).
  - Beat without in_first in IDLE: treated as first.
  - in_first && in_last: single-beat packet, identical to normal mode.

## Configuration
- LOGIC_UNIT_ACCUM_EN defined: accumulate mode active.
  - First beat loads acc = a and latches op for the packet; later beats compute acc = f(acc, a); b is ignored.
  - Mid-packet op changes are ignored.
  - PASS fold yields the last word.
  - Inversion is applied once, at output: y = op[2] ? ~acc_final : acc_final.
- Not defined: in_first/in_last ignored, no accumulator or state machine; every beat is a normal-mode beat. Ports remain present.

## Structure
- Package logic_unit_pkg holds the op_e enum (OP_AND, OP_OR, OP_XOR, OP_PASS), the OP_INV_BIT index constant, and the acc_state_e enum (IDLE, ACC).
- One sub-module, logic_unit_core: a combinational WIDTH-parametrised f(x, a, b, op[1:0]), reused for both normal and fold paths.

## Test plan
- WIDTH=4, out_ready=1, a=4'b1100, b=4'b1010, sweep op 000..111.
  - Expected y: 1000, 1110, 0110, 1100, 0111, 0001, 1001, 0011, one cycle after each beat.
  - red_xor after op 000 (y=1000) = 1.
- Backpressure: accept a beat, hold out_ready=0 for 3 cycles -> in_ready=0 and y stable. Then out_ready=1 with a new beat offered in the same cycle -> drain and load in one cycle, no bubble.
- WIDTH=8 AND op, a=8'hFF -> red_and=1. Then a=8'hFE -> red_and=0, red_or=1.
- ACCUM_EN, op=000, three beats a=F0, 3C, FF (first/last marked) -> one output, y=30, one cycle after the last beat.
- ACCUM_EN, op=110, beats a=0F, F0, then in_first a=AA with in_last -> partial dropped, y=55.
- Assert rst_n low mid-packet in ACC -> out_valid=0, y=0. The next single beat op=001, a=01, b=02 (in_first, in_last) -> y=03.
